// File: rtl/uart_core.sv
// uart_core: memory-mapped 8N1 UART with CTRL/STATUS/BAUD/TX/RX registers
module uart_core #(
   parameter logic [15:0] BAUD_RESET = 16'h01B8
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        req_i,
   input  logic        we_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] wdata_i,
   output logic [31:0] rdata_o,
   output logic        tx_o,
   input  logic        rx_i
);
   typedef enum logic [1:0] {T_IDLE, T_START, T_DATA, T_STOP} tx_state_t;
   typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;

   tx_state_t   t_state, t_next;
   rx_state_t   r_state, r_next;
   logic        tx_en, rx_en, rx_over, frame_err;
   logic [15:0] baud, t_cnt, r_cnt;
   logic [7:0]  tx_data, rx_data, r_shift;
   logic [2:0]  t_bit, r_bit;
   logic        rx_m, rx_s, rx_prev;
   logic        wr, wr_ctrl, wr_status, wr_baud, tx_go, tx_busy;
   logic        t_tick, t_load, r_tick, rx_good, rx_bad;
   logic [7:0]  a;
   logic        unused_bits;

   assign a           = addr_i[7:0];
   assign unused_bits = ^{addr_i[31:8], wdata_i[31:16]};
   assign wr          = req_i & we_i;
   assign wr_ctrl     = wr && a == 8'h00;
   assign wr_status   = wr && a == 8'h04;
   assign wr_baud     = wr && a == 8'h08;
   assign tx_busy     = t_state != T_IDLE;
   assign tx_go       = wr && a == 8'h0C && tx_en && !tx_busy;
   assign t_tick      = t_cnt == 16'd0;
   assign t_load      = (t_state == T_IDLE) ? tx_go : t_tick;
   assign r_tick      = r_cnt == 16'd0;
   assign rx_good     = r_state == R_STOP && r_tick && rx_en && rx_s;
   assign rx_bad      = r_state == R_STOP && r_tick && rx_en && !rx_s;

   assign rdata_o = (a == 8'h00) ? {30'd0, rx_en, tx_en} :
                    (a == 8'h04) ? {29'd0, frame_err, rx_over, tx_busy} :
                    (a == 8'h08) ? {16'd0, baud} :
                    (a == 8'h0C) ? {24'd0, tx_data} :
                    (a == 8'h10) ? {24'd0, rx_data} : 32'd0;

   // register file; a flag set by the receiver beats a same-cycle clear
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         tx_en     <= 1'b0;
         rx_en     <= 1'b0;
         baud      <= BAUD_RESET;
         tx_data   <= 8'd0;
         rx_data   <= 8'd0;
         rx_over   <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         if (wr_ctrl) begin
            tx_en <= wdata_i[0];
            rx_en <= wdata_i[1];
         end
         if (wr_baud) baud <= (wdata_i[15:0] < 16'd4) ? 16'd4 : wdata_i[15:0];
         if (tx_go) tx_data <= wdata_i[7:0];
         if (rx_good) rx_data <= r_shift;
         rx_over   <= rx_good | (rx_over & ~(wr_status & ~wdata_i[1]));
         frame_err <= rx_bad | (frame_err & ~(wr_status & ~wdata_i[2]));
      end
   end

   // two-flop synchronizer plus one history flop for falling-edge detection
   always_ff @(posedge clk_i) begin
      {rx_prev, rx_s, rx_m} <= rst_i ? 3'b111 : {rx_s, rx_m, rx_i};
   end

   // transmitter state and bit timing; counter reloads from the live BAUD value
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         t_state <= T_IDLE;
         t_cnt   <= 16'd0;
         t_bit   <= 3'd0;
      end else begin
         t_state <= t_next;
         t_cnt   <= t_load ? baud - 16'd1 : t_cnt - 16'd1;
         t_bit   <= (t_state != T_DATA) ? 3'd0 : t_bit + {2'b0, t_tick};
      end
   end

   // transmitter next state and serial output
   always_comb begin
      t_next = t_state;
      tx_o   = 1'b1;
      case (t_state)
         T_IDLE:  t_next = tx_go ? T_START : T_IDLE;
         T_START: begin
            tx_o   = 1'b0;
            t_next = t_tick ? T_DATA : T_START;
         end
         T_DATA:  begin
            tx_o   = tx_data[t_bit];
            t_next = (t_tick && t_bit == 3'd7) ? T_STOP : T_DATA;
         end
         T_STOP:  t_next = t_tick ? T_IDLE : T_STOP;
      endcase
   end

   // receiver state, half-bit then full-bit sample timing, shift-in LSB first
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= R_IDLE;
         r_cnt   <= 16'd0;
         r_bit   <= 3'd0;
         r_shift <= 8'd0;
      end else begin
         r_state <= r_next;
         r_cnt   <= (r_state == R_IDLE) ? {1'b0, baud[15:1]} - 16'd1 : (r_tick ? baud - 16'd1 : r_cnt - 16'd1);
         r_bit   <= (r_state != R_DATA) ? 3'd0 : r_bit + {2'b0, r_tick};
         if (r_state == R_DATA && r_tick) r_shift <= {rx_s, r_shift[7:1]};
      end
   end

   // receiver next state; dropping rx_en abandons any frame in progress
   always_comb begin
      r_next = r_state;
      case (r_state)
         R_IDLE:  r_next = (rx_en && rx_prev && !rx_s) ? R_START : R_IDLE;
         R_START: r_next = !r_tick ? R_START : (rx_s ? R_IDLE : R_DATA);
         R_DATA:  r_next = (r_tick && r_bit == 3'd7) ? R_STOP : R_DATA;
         R_STOP:  r_next = r_tick ? R_IDLE : R_STOP;
      endcase
      if (!rx_en) r_next = R_IDLE;
   end
endmodule

// File: tb/tb_uart_core.sv
// tb_uart_core: randomized bench checking uart_core against a frame-level model
module tb_uart_core;
   logic        clk_i = 1'b0;
   logic        rst_i, req_i, we_i, tx_o, rx_i;
   logic [31:0] addr_i, wdata_i, rdata_o;

   uart_core dut (
      .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
      .wdata_i(wdata_i), .rdata_o(rdata_o), .tx_o(tx_o), .rx_i(rx_i)
   );

   always #5 clk_i = ~clk_i;

   int          n_chk = 0, n_pass = 0;
   int          cyc = 0;
   bit          chk_on = 1'b0;
   bit          m_tx_en, m_rx_en, m_over, m_fe;
   logic [15:0] m_baud = 16'h01B8;
   logic [7:0]  m_tx, m_rx;
   bit          tx_act;
   int          tx_n, tx_b;
   bit          pend;
   int          pend_edge;
   logic [7:0]  pend_d;
   bit          pend_s;
   logic [9:0]  exp_bits;
   logic [7:0]  d;
   bit          s;
   int          s_edge;
   logic [7:0]  rd_addrs [9] = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h40, 8'hFF, 8'h01};

   // a frame accepted at edge n occupies periods n .. n+10*B-1
   function automatic bit m_busy(int m);
      return tx_act && m >= tx_n && (m - tx_n) < 10 * tx_b;
   endfunction

   function automatic bit m_txo(int m);
      int k;
      if (!m_busy(m)) return 1'b1;
      k = (m - tx_n) / tx_b;
      if (k == 0) return 1'b0;
      if (k <= 8) return m_tx[k-1];
      return 1'b1;
   endfunction

   function automatic logic [31:0] m_read(logic [7:0] a);
      case (a)
         8'h00:   return {30'd0, m_rx_en, m_tx_en};
         8'h04:   return {29'd0, m_fe, m_over, m_busy(cyc)};
         8'h08:   return {16'd0, m_baud};
         8'h0C:   return {24'd0, m_tx};
         8'h10:   return {24'd0, m_rx};
         default: return 32'd0;
      endcase
   endfunction

   task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, act, exp);
   endtask

   // model update at each edge from the bus inputs and scheduled receive outcomes
   always @(posedge clk_i) begin
      bit so, sf;
      logic [7:0] a;
      cyc++;
      so = 1'b0;
      sf = 1'b0;
      a  = addr_i[7:0];
      if (rst_i) begin
         m_tx_en = 0; m_rx_en = 0; m_over = 0; m_fe = 0;
         m_baud = 16'h01B8; m_tx = 0; m_rx = 0; tx_act = 0; pend = 0;
      end else begin
         if (pend && !m_rx_en) pend = 0;
         if (pend && cyc == pend_edge) begin
            pend = 0;
            if (pend_s) begin
               m_rx = pend_d;
               so = 1'b1;
            end else sf = 1'b1;
         end
         if (req_i && we_i) begin
            if (a == 8'h04) begin
               m_over = m_over & wdata_i[1];
               m_fe   = m_fe & wdata_i[2];
            end
            if (a == 8'h00) begin
               m_tx_en = wdata_i[0];
               m_rx_en = wdata_i[1];
            end
            if (a == 8'h08) m_baud = (wdata_i[15:0] < 16'd4) ? 16'd4 : wdata_i[15:0];
            if (a == 8'h0C && m_tx_en && !m_busy(cyc - 1)) begin
               tx_act = 1; tx_n = cyc; tx_b = int'(m_baud); m_tx = wdata_i[7:0];
            end
         end
         m_over = m_over | so;
         m_fe   = m_fe | sf;
      end
   end

   // every-cycle comparison of serial output and read data
   always @(negedge clk_i) begin
      if (chk_on) begin
         check("tx_o", {31'd0, tx_o}, {31'd0, m_txo(cyc)});
         check("rdata", rdata_o, m_read(addr_i[7:0]));
      end
   end

   task automatic idle(int n);
      repeat (n) @(posedge clk_i);
      #2;
   endtask

   task automatic set_addr(logic [7:0] a);
      logic [31:0] r;
      r = $urandom;
      addr_i = {r[31:8], a};
   endtask

   task automatic bus_write(logic [7:0] a, logic [31:0] dat);
      set_addr(a);
      req_i = 1; we_i = 1; wdata_i = dat;
      idle(1);
      req_i = 0; we_i = 0;
   endtask

   task automatic lit(string nm, logic [7:0] a, logic [31:0] exp);
      set_addr(a);
      @(negedge clk_i);
      #1;
      check(nm, rdata_o, exp);
      idle(1);
   endtask

   // drives one 8N1 frame; when tracked, the outcome lands at the stop-sample edge
   task automatic send_rx(logic [7:0] dat, bit stp, bit track);
      logic [9:0] fr;
      int b;
      b  = int'(m_baud);
      fr = {stp, dat, 1'b0};
      if (track) begin
         pend = 1; pend_edge = cyc + 3 + b / 2 + 9 * b; pend_d = dat; pend_s = stp;
      end
      for (int i = 0; i < 10; i++) begin
         rx_i = fr[i];
         idle(b);
      end
      rx_i = 1'b1;
   endtask

   task automatic glitch();
      rx_i = 1'b0;
      idle(2);
      rx_i = 1'b1;
   endtask

   initial begin
      rst_i = 1; req_i = 0; we_i = 0; addr_i = 0; wdata_i = 0; rx_i = 1;
      exp_bits = 10'b1101001010;
      repeat (2) @(posedge clk_i);
      #2;
      rst_i  = 0;
      chk_on = 1;
      lit("rst_baud", 8'h08, 32'h1B8);
      lit("rst_ctrl", 8'h00, 32'h0);
      lit("rst_status", 8'h04, 32'h0);
      @(negedge clk_i);
      #1;
      check("rst_tx_o", {31'd0, tx_o}, 32'd1);
      idle(1);
      bus_write(8'h08, 32'd2);
      lit("baud_clamp", 8'h08, 32'd4);
      bus_write(8'h00, 32'd3);
      bus_write(8'h08, 32'd8);
      bus_write(8'h0C, 32'hA5);
      idle(4);
      for (int j = 0; j < 10; j++) begin
         set_addr(8'h04);
         @(negedge clk_i);
         #1;
         check("a5_bit", {31'd0, tx_o}, {31'd0, exp_bits[j]});
         check("a5_busy", {31'd0, rdata_o[0]}, 32'd1);
         if (j == 3) begin
            idle(1);
            bus_write(8'h0C, 32'h3C);
            idle(6);
         end else idle(8);
      end
      lit("tx_keep", 8'h0C, 32'hA5);
      lit("tx_idle", 8'h04, 32'h0);
      idle(20);
      send_rx(8'h5A, 1, 1);
      idle(4);
      lit("rx_5a", 8'h10, 32'h5A);
      lit("st_over", 8'h04, 32'h2);
      bus_write(8'h04, 32'h0);
      lit("st_clr", 8'h04, 32'h0);
      send_rx(8'h77, 0, 1);
      idle(4);
      lit("st_fe", 8'h04, 32'h4);
      lit("rx_keep", 8'h10, 32'h5A);
      glitch();
      idle(14);
      lit("glitch", 8'h04, 32'h4);
      bus_write(8'h04, 32'h0);
      repeat (40) begin
         case ($urandom_range(0, 5))
            0, 1: bus_write(8'h0C, $urandom);
            2: bus_write(8'h00, {30'd0, 1'b1, ($urandom_range(0, 3) != 0)});
            3: if (!m_busy(cyc)) bus_write(8'h08, $urandom_range(0, 12));
            4: bus_write(($urandom_range(0, 1) != 0) ? 8'h04 : 8'h14, $urandom);
            default: begin
               set_addr(rd_addrs[$urandom_range(0, 8)]);
               req_i = 1; we_i = 0;
               idle(1);
               req_i = 0;
            end
         endcase
         idle($urandom_range(1, 25));
      end
      idle(130);
      bus_write(8'h00, 32'd3);
      for (int i = 0; i < 8; i++) begin
         if (i % 2 == 0) bus_write(8'h08, $urandom_range(4, 12));
         d = $urandom;
         s = ($urandom_range(0, 3) != 0);
         if (i == 3) begin
            fork
               send_rx(d, s, 1);
               begin
                  idle(20);
                  bus_write(8'h00, 32'd1);
               end
            join
            idle(6);
            bus_write(8'h00, 32'd3);
         end else if (i == 5) begin
            s_edge = cyc + 3 + int'(m_baud) / 2 + 9 * int'(m_baud);
            fork
               send_rx(d, s, 1);
               begin
                  idle(s_edge - 1 - cyc);
                  bus_write(8'h04, 32'h0);
               end
            join
            idle(6);
         end else begin
            send_rx(d, s, 1);
            idle(6);
         end
         if ($urandom_range(0, 1) != 0) bus_write(8'h04, 32'h0);
      end
      glitch();
      idle(20);
      bus_write(8'h08, 32'd8);
      fork
         send_rx(8'hC3, 1, 1);
         begin
            bus_write(8'h0C, 32'h81);
            idle(30);
            set_addr(8'h04);
            @(negedge clk_i);
            #1;
            check("pre_rst_busy", {31'd0, rdata_o[0]}, 32'd1);
            idle(1);
            rst_i = 1;
            idle(1);
            rst_i = 0;
            @(negedge clk_i);
            #1;
            check("post_rst_tx_o", {31'd0, tx_o}, 32'd1);
            check("post_rst_status", rdata_o, 32'd0);
            idle(1);
         end
      join
      idle(4);
      lit("post_rst_rx", 8'h10, 32'h0);
      lit("post_rst_baud", 8'h08, 32'h1B8);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
